// File: rtl/score_bcd_display.sv
// Score display: converts a binary count to BCD one bit per clock (double-dabble)
// and drives two seven-segment digits plus an over-99 flag. Optional: LEADING_ZERO_BLANK_EN.
module score_bcd_display #(
  parameter int WIDTH          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  output logic [6:0]       seg_ones,
  output logic [6:0]       seg_tens,
  output logic             over99,
  output logic             busy,
  output logic             valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);
  localparam logic [6:0] ZERO_CODE = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] last_count_q, last_count_d;
  logic [WIDTH-1:0] captured_q, captured_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [11:0]      disp_bcd_q, disp_bcd_d;
  logic [6:0]       seg_ones_q, seg_ones_d;
  logic [6:0]       seg_tens_q, seg_tens_d;
  logic             over99_q, over99_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic [11:0]      bcd_adj;
  logic             tens_blank;

  // Active-low pattern for one digit, flipped afterwards for active-high boards.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit, input logic blank);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = 7'b1111111;
    endcase
    if (blank) code = 7'b1111111;
    return SEG_ACTIVE_LOW ? code : ~code;
  endfunction

  always_comb begin
    bcd_adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
    bcd_adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign tens_blank = (bcd_q[7:4] == 4'd0) && (bcd_q[11:8] == 4'd0);
`else
  assign tens_blank = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_count_d = last_count_q;
    captured_d   = captured_q;
    shifter_d    = shifter_q;
    bcd_d        = bcd_q;
    bit_cnt_d    = bit_cnt_q;
    disp_bcd_d   = disp_bcd_q;
    seg_ones_d   = seg_ones_q;
    seg_tens_d   = seg_tens_q;
    over99_d     = over99_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count != last_count_q) begin
          captured_d = count;
          shifter_d  = count;
          bcd_d      = 12'd0;
          bit_cnt_d  = 4'd0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d     = {bcd_adj[10:0], shifter_q[WIDTH-1]};
        shifter_d = {shifter_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == LAST_STEP) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // Segments come straight from the finished accumulator so they land with valid.
        disp_bcd_d   = bcd_q;
        seg_ones_d   = seg_encode(bcd_q[3:0], 1'b0);
        seg_tens_d   = seg_encode(bcd_q[7:4], tens_blank);
        over99_d     = (bcd_q[11:8] != 4'd0);
        last_count_d = captured_q;
        valid_d      = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_count_q <= '0;
      captured_q   <= '0;
      shifter_q    <= '0;
      bcd_q        <= 12'd0;
      bit_cnt_q    <= 4'd0;
      disp_bcd_q   <= 12'd0;
      seg_ones_q   <= ZERO_CODE;
      seg_tens_q   <= ZERO_CODE;
      over99_q     <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_count_q <= last_count_d;
      captured_q   <= captured_d;
      shifter_q    <= shifter_d;
      bcd_q        <= bcd_d;
      bit_cnt_q    <= bit_cnt_d;
      disp_bcd_q   <= disp_bcd_d;
      seg_ones_q   <= seg_ones_d;
      seg_tens_q   <= seg_tens_d;
      over99_q     <= over99_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign seg_ones = seg_ones_q;
  assign seg_tens = seg_tens_q;
  assign over99   = over99_q;
  assign busy     = busy_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed bench for score_bcd_display (WIDTH=8, active-low segments);
// tens-digit expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_score_bcd_display;

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = BLANK;
`else
  localparam logic [6:0] LEAD_ZERO = C0;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] count;
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
  logic       over99;
  logic       busy;
  logic       valid;

  int checks = 0;
  int errors = 0;
  int valid_pulses = 0;

  score_bcd_display #(.WIDTH(8), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clock    (clock),
    .reset    (reset),
    .count    (count),
    .seg_ones (seg_ones),
    .seg_tens (seg_tens),
    .over99   (over99),
    .busy     (busy),
    .valid    (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    if (valid === 1'b1) valid_pulses++;
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    count = value;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, {6'd0, valid}, 7'd1);
  endtask

  initial begin
    reset = 1'b1;
    count = 8'd0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (12) tick();
    $display("[TB] reset state, count held at 0");
    checkOutput("reset_tens", seg_tens, C0);
    checkOutput("reset_ones", seg_ones, C0);
    checkOutput("reset_over99", {6'd0, over99}, 7'd0);
    checkOutput("reset_busy", {6'd0, busy}, 7'd0);
    checkOutput("reset_no_valid", 7'(valid_pulses), 7'd0);

    $display("[TB] 0 -> 42 latency");
    applyStimulus(8'd42);
    tick();
    checkOutput("c42_busy_e0", {6'd0, busy}, 7'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput("c42_busy_mid", {busy, valid, 5'd0}, 7'b1000000);
      checkOutput("c42_tens_stable", seg_tens, C0);
    end
    tick();
    checkOutput("c42_valid_e9", {busy, valid, 5'd0}, 7'b0100000);
    checkOutput("c42_tens", seg_tens, C4);
    checkOutput("c42_ones", seg_ones, C2);
    checkOutput("c42_over99", {6'd0, over99}, 7'd0);
    tick();
    checkOutput("c42_valid_drop", {6'd0, valid}, 7'd0);

    $display("[TB] 255 then 99");
    applyStimulus(8'd255);
    waitValid("c255_valid");
    checkOutput("c255_tens", seg_tens, C5);
    checkOutput("c255_ones", seg_ones, C5);
    checkOutput("c255_over99", {6'd0, over99}, 7'd1);
    tick();
    applyStimulus(8'd99);
    waitValid("c99_valid");
    checkOutput("c99_tens", seg_tens, C9);
    checkOutput("c99_ones", seg_ones, C9);
    checkOutput("c99_over99", {6'd0, over99}, 7'd0);
    tick();

    $display("[TB] count changes mid-conversion");
    valid_pulses = 0;
    applyStimulus(8'd10);
    tick();
    tick();
    tick();
    applyStimulus(8'd11);
    repeat (6) tick();
    checkOutput("c10_no_early_valid", {6'd0, valid}, 7'd0);
    tick();
    checkOutput("c10_valid_e9", {6'd0, valid}, 7'd1);
    checkOutput("c10_tens", seg_tens, C1);
    checkOutput("c10_ones", seg_ones, C0);
    tick();
    checkOutput("c11_restart_busy", {busy, valid, 5'd0}, 7'b1000000);
    repeat (8) tick();
    checkOutput("c11_no_early_valid", {6'd0, valid}, 7'd0);
    tick();
    checkOutput("c11_valid_e19", {6'd0, valid}, 7'd1);
    checkOutput("c11_tens", seg_tens, C1);
    checkOutput("c11_ones", seg_ones, C1);
    repeat (8) tick();
    checkOutput("c10_c11_pulses", 7'(valid_pulses), 7'd2);

    $display("[TB] reset during conversion");
    valid_pulses = 0;
    applyStimulus(8'd37);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_busy", {busy, valid, 5'd0}, 7'b0000000);
    checkOutput("rst_tens", seg_tens, C0);
    checkOutput("rst_ones", seg_ones, C0);
    checkOutput("rst_over99", {6'd0, over99}, 7'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_restart_busy", {6'd0, busy}, 7'd1);
    checkOutput("rst_no_valid", 7'(valid_pulses), 7'd0);
    waitValid("c37_valid");
    checkOutput("c37_tens", seg_tens, C3);
    checkOutput("c37_ones", seg_ones, C7);
    tick();

    $display("[TB] leading-zero cases");
    applyStimulus(8'd7);
    waitValid("c7_valid");
    checkOutput("c7_tens", seg_tens, LEAD_ZERO);
    checkOutput("c7_ones", seg_ones, C7);
    tick();
    applyStimulus(8'd0);
    waitValid("c0_valid");
    checkOutput("c0_tens", seg_tens, LEAD_ZERO);
    checkOutput("c0_ones", seg_ones, C0);
    tick();
    applyStimulus(8'd105);
    waitValid("c105_valid");
    checkOutput("c105_tens", seg_tens, C0);
    checkOutput("c105_ones", seg_ones, C5);
    checkOutput("c105_over99", {6'd0, over99}, 7'd1);
    tick();

    $display("[TB] unchanged count stays quiet");
    valid_pulses = 0;
    repeat (15) tick();
    checkOutput("same_no_valid", 7'(valid_pulses), 7'd0);
    checkOutput("same_not_busy", {6'd0, busy}, 7'd0);
    checkOutput("same_tens_held", seg_tens, C0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
